// File: rtl/plic_irq_arbiter.sv
// Per-source edge gateways, a priority arbiter and a claim/complete sequencer driving one core IRQ.
// Optional PLIC_EDGE_QUEUE_EN: queue up to 3 edges per source that arrive while it is busy.
module plic_irq_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SRC-1:0] src_irq_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              irq_o
);

  localparam int unsigned IdW = $clog2(NUM_SRC + 1);

  typedef enum logic [1:0] {GwIdle, GwPending, GwInflight} gw_e;

  gw_e                gw_q [NUM_SRC];
  gw_e                gw_d [NUM_SRC];
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [NUM_SRC-1:0] src_q, edge_s, pend, claimed, cmpl;
  logic [NUM_SRC-1:0] en_q;
  logic [PRIO_W-1:0]  thr_q;
  logic [IdW-1:0]     best_id_q, best_id_d;
  logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               irq_q, irq_cond, claim_req, claim_ok, cmpl_req;
  logic [7:0]         waddr, raddr;
  logic               unused_bits;
`ifdef PLIC_EDGE_QUEUE_EN
  logic [1:0]         cnt_q [NUM_SRC];
  logic [1:0]         cnt_d [NUM_SRC];
`endif

  assign waddr       = waddr_i[7:0];
  assign raddr       = raddr_i[7:0];
  assign unused_bits = ^{waddr_i[ADDR_W-1:8], raddr_i[ADDR_W-1:8], wdata_i[DATA_W-1:8]};

  assign edge_s    = src_irq_i & ~src_q;
  assign irq_cond  = (best_id_q != '0) && (best_prio_q > thr_q);
  assign claim_req = re_i && (raddr == 8'h2C);
  assign claim_ok  = claim_req && irq_cond;
  assign cmpl_req  = we_i && (waddr == 8'h2C);

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      claimed[k] = claim_ok && (best_id_q == IdW'(k + 1));
      cmpl[k]    = cmpl_req && (wdata_i[7:0] == 8'(k + 1)) && (gw_q[k] == GwInflight);
    end
  end

  // Gateway state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        gw_q[k] <= GwIdle;
`ifdef PLIC_EDGE_QUEUE_EN
        cnt_q[k] <= 2'd0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        gw_q[k] <= gw_d[k];
`ifdef PLIC_EDGE_QUEUE_EN
        cnt_q[k] <= cnt_d[k];
`endif
      end
    end
  end

  // Gateway next state
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      gw_d[k] = gw_q[k];
`ifdef PLIC_EDGE_QUEUE_EN
      cnt_d[k] = cnt_q[k];
`endif
      unique case (gw_q[k])
        GwIdle: if (edge_s[k]) gw_d[k] = GwPending;
        GwPending: begin
          if (claimed[k]) gw_d[k] = GwInflight;
`ifdef PLIC_EDGE_QUEUE_EN
          if (edge_s[k] && cnt_q[k] != 2'd3) cnt_d[k] = cnt_q[k] + 2'd1;
`endif
        end
        GwInflight: begin
          if (cmpl[k]) begin
            // A fresh edge alongside its own complete re-arms the source at once
            if (edge_s[k]) gw_d[k] = GwPending;
`ifdef PLIC_EDGE_QUEUE_EN
            else if (cnt_q[k] != 2'd0) begin
              gw_d[k]  = GwPending;
              cnt_d[k] = cnt_q[k] - 2'd1;
            end
`endif
            else gw_d[k] = GwIdle;
          end
`ifdef PLIC_EDGE_QUEUE_EN
          else if (edge_s[k] && cnt_q[k] != 2'd3) cnt_d[k] = cnt_q[k] + 2'd1;
`endif
        end
        default: gw_d[k] = GwIdle;
      endcase
    end
  end

  // Gateway outputs
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) pend[k] = (gw_q[k] == GwPending);
  end

  // Strict '>' over ascending IDs keeps the lowest ID on a priority tie
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pend[k] && en_q[k] && !claimed[k] && (prio_q[k] > best_prio_d)) begin
        best_id_d   = IdW'(k + 1);
        best_prio_d = prio_q[k];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = '0;
      case (raddr)
        8'h20: rdata_d[NUM_SRC-1:0] = pend;
        8'h24: rdata_d[NUM_SRC-1:0] = en_q;
        8'h28: rdata_d[PRIO_W-1:0]  = thr_q;
        8'h2C: rdata_d[IdW-1:0]     = claim_ok ? best_id_q : '0;
        default: begin
          for (int k = 0; k < NUM_SRC; k++) begin
            if (raddr == 8'(4 * k)) rdata_d[PRIO_W-1:0] = prio_q[k];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_SRC; k++) prio_q[k] <= '0;
      en_q        <= '0;
      thr_q       <= '0;
      src_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (we_i) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (waddr == 8'(4 * k)) prio_q[k] <= wdata_i[PRIO_W-1:0];
        end
        if (waddr == 8'h24) en_q  <= wdata_i[NUM_SRC-1:0];
        if (waddr == 8'h28) thr_q <= wdata_i[PRIO_W-1:0];
      end
      src_q       <= src_irq_i;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      irq_q       <= irq_cond;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_plic_irq_arbiter.sv
// Bench for plic_irq_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_plic_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_irq;
  logic        we, re;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: gateway 0 idle, 1 pending, 2 in flight
  int         m_gw [3];
  int         m_prio [3];
  int         m_en, m_thr, m_best_id, m_best_prio;
  logic       m_irq;
  logic [31:0] m_rdata;
  logic [2:0] m_src_prev;
`ifdef PLIC_EDGE_QUEUE_EN
  int         m_cnt [3];
`endif

  plic_irq_arbiter dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .src_irq_i(src_irq),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .re_i     (re),
    .raddr_i  (raddr),
    .rdata_o  (rdata),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_gw[i]   = 0;
      m_prio[i] = 0;
`ifdef PLIC_EDGE_QUEUE_EN
      m_cnt[i] = 0;
`endif
    end
    m_en = 0; m_thr = 0; m_best_id = 0; m_best_prio = 0;
    m_irq = 1'b0; m_rdata = '0; m_src_prev = '0;
  endtask

  task automatic model_step();
    int cond, cl, cid, nb_id, nb_p, rd;
    bit e;
    cond = (m_best_id != 0 && m_best_prio > m_thr) ? 1 : 0;
    cl = 0;
    if (re) begin
      rd = 0;
      case (raddr[7:0])
        8'h00: rd = m_prio[0];
        8'h04: rd = m_prio[1];
        8'h08: rd = m_prio[2];
        8'h20: for (int i = 0; i < 3; i++) if (m_gw[i] == 1) rd = rd | (1 << i);
        8'h24: rd = m_en;
        8'h28: rd = m_thr;
        8'h2C: begin cl = cond ? m_best_id : 0; rd = cl; end
        default: rd = 0;
      endcase
      m_rdata = 32'(rd);
    end
    // Highest priority among eligible sources; first found wins ties
    nb_id = 0; nb_p = 0;
    for (int i = 0; i < 3; i++)
      if (m_gw[i] == 1 && m_en[i] && m_prio[i] > nb_p && (i + 1) != cl) begin
        nb_id = i + 1; nb_p = m_prio[i];
      end
    cid = (we && waddr[7:0] == 8'h2C) ? int'(wdata[7:0]) : 0;
    for (int i = 0; i < 3; i++) begin
      e = src_irq[i] && !m_src_prev[i];
      if (m_gw[i] == 0) begin
        if (e) m_gw[i] = 1;
      end else if (m_gw[i] == 1) begin
        if (cl == i + 1) m_gw[i] = 2;
`ifdef PLIC_EDGE_QUEUE_EN
        if (e && m_cnt[i] < 3) m_cnt[i]++;
`endif
      end else if (cid == i + 1) begin
        if (e) m_gw[i] = 1;
`ifdef PLIC_EDGE_QUEUE_EN
        else if (m_cnt[i] > 0) begin m_gw[i] = 1; m_cnt[i]--; end
`endif
        else m_gw[i] = 0;
      end
`ifdef PLIC_EDGE_QUEUE_EN
      else if (e && m_cnt[i] < 3) m_cnt[i]++;
`endif
    end
    if (we) begin
      case (waddr[7:0])
        8'h00: m_prio[0] = int'(wdata[2:0]);
        8'h04: m_prio[1] = int'(wdata[2:0]);
        8'h08: m_prio[2] = int'(wdata[2:0]);
        8'h24: m_en = int'(wdata[2:0]);
        8'h28: m_thr = int'(wdata[2:0]);
        default: ;
      endcase
    end
    m_irq = (cond != 0);
    m_best_id = nb_id; m_best_prio = nb_p;
    m_src_prev = src_irq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("irq_o", 32'(irq), 32'(m_irq));
    if (re) check("rdata_o", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; waddr = {24'h0, a}; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    re = 1'b1; raddr = {24'h0, a};
    tick();
    d = rdata;
    re = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] m);
    src_irq = m;
    tick();
    src_irq = 3'b000;
  endtask

  logic [31:0] v;
  logic [7:0]  addr_tab [8];

  initial begin
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30};
    rst = 1'b1; src_irq = '0; we = 1'b0; re = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    model_reset();
    #1;
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source through the whole latency chain
    wr(8'h00, 32'd2); wr(8'h24, 32'd1); wr(8'h28, 32'd0);
    pulse(3'b001);
    idle(2);
    check("t1_irq_up", 32'(irq), 32'd1);
    rd(8'h2C, v);
    check("t1_claim", v, 32'd1);
    tick();
    check("t1_irq_down", 32'(irq), 32'd0);
    wr(8'h2C, 32'd1);

    // Three simultaneous sources, claimed back to back
    wr(8'h00, 32'd3); wr(8'h04, 32'd3); wr(8'h08, 32'd5); wr(8'h24, 32'd7);
    pulse(3'b111);
    idle(2);
    rd(8'h2C, v); check("t2_claim_first", v, 32'd3);
    rd(8'h2C, v);
    rd(8'h2C, v);
    rd(8'h2C, v); check("t2_claim_empty", v, 32'd0);
    wr(8'h2C, 32'd1); wr(8'h2C, 32'd2); wr(8'h2C, 32'd3);

    // Threshold masking
    wr(8'h28, 32'd4); wr(8'h00, 32'd4); wr(8'h24, 32'd1);
    pulse(3'b001);
    idle(3);
    check("t3_irq_masked", 32'(irq), 32'd0);
    rd(8'h2C, v); check("t3_claim_masked", v, 32'd0);
    wr(8'h28, 32'd3);
    idle(1);
    check("t3_irq_unmasked", 32'(irq), 32'd1);
    rd(8'h2C, v); check("t3_claim", v, 32'd1);
    wr(8'h2C, 32'd1);

    // Edge while in flight
    wr(8'h28, 32'd0); wr(8'h04, 32'd3); wr(8'h24, 32'd2);
    pulse(3'b010); idle(2);
    rd(8'h2C, v); check("t4_claim", v, 32'd2);
    pulse(3'b010); idle(3);
    rd(8'h2C, v); check("t4_busy_edge", v, 32'd0);
    wr(8'h2C, 32'd2); idle(2);
    rd(8'h2C, v);
`ifdef PLIC_EDGE_QUEUE_EN
    check("t4_queued", v, 32'd2);
`else
    check("t4_dropped", v, 32'd0);
    pulse(3'b010); idle(2);
    rd(8'h2C, v); check("t4_reclaim", v, 32'd2);
`endif

    // Ignored completes, then complete with a same-cycle edge
    wr(8'h2C, 32'd0); wr(8'h2C, 32'd5); wr(8'h2C, 32'd1);
    rd(8'h20, v); check("t5_no_pending", v, 32'd0);
    src_irq = 3'b010; we = 1'b1; waddr = 32'h2C; wdata = 32'd2;
    tick();
    src_irq = 3'b000; we = 1'b0;
    rd(8'h20, v); check("t5_rearm", v, 32'd2);

    // Asynchronous reset with a source in flight and irq asserted
    idle(2);
    rd(8'h2C, v); check("t6_claim", v, 32'd2);
    wr(8'h00, 32'd2); wr(8'h24, 32'd3);
    pulse(3'b001); idle(2);
    check("t6_irq_up", 32'(irq), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_rdata", rdata, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rd(8'h20, v); check("t6_rst_pending", v, 32'd0);
    rd(8'h24, v); check("t6_rst_enable", v, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      src_irq = 3'($urandom) & 3'($urandom);
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      waddr = {24'($urandom), addr_tab[$urandom_range(0, 7)]};
      raddr = {24'($urandom), addr_tab[$urandom_range(0, 7)]};
      if (waddr[7:0] == 8'h24 || waddr[7:0] == 8'h2C)
        wdata = {24'($urandom), 8'($urandom_range(0, 5))};
      else
        wdata = $urandom;
      tick();
    end
    we = 1'b0; re = 1'b0; src_irq = '0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
